// File: rtl/btb_next_pc_pkg.sv
// btb_next_pc_pkg: shared widths, reset PC and BTB entry layout for the next-PC stage.
package btb_next_pc_pkg;
  localparam int PC_WIDTH = 32;
  localparam int BTB_IDX_WIDTH = 6;
  localparam logic [PC_WIDTH-1:0] RESET_PC = 32'h8000_0000;
  localparam int BTB_TAG_WIDTH = PC_WIDTH - BTB_IDX_WIDTH - 2;
  localparam int BTB_LEN = 1 << BTB_IDX_WIDTH;
  typedef struct packed {
    logic [BTB_TAG_WIDTH-1:0] tag;
    logic [PC_WIDTH-1:0] target;
    logic is_jump;
  } btb_entry_t;
  function automatic logic [BTB_IDX_WIDTH-1:0] pc_idx(input logic [PC_WIDTH-1:0] a);
    return a[BTB_IDX_WIDTH+1:2];
  endfunction
  function automatic logic [BTB_TAG_WIDTH-1:0] pc_tag(input logic [PC_WIDTH-1:0] a);
    return a[PC_WIDTH-1:BTB_IDX_WIDTH+2];
  endfunction
endpackage

// File: rtl/btb_array.sv
// btb_array: direct-mapped BTB with dual prioritised update, flush and lookup.
// Same-cycle update forwarding is built when BTB_BYPASS_EN is defined.
module btb_array
  import btb_next_pc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_flush,
  input  logic                i_en_first,
  input  logic [PC_WIDTH-1:0] i_pc_first,
  input  logic [PC_WIDTH-1:0] i_target_first,
  input  logic                i_is_jump_first,
  input  logic                i_en_second,
  input  logic [PC_WIDTH-1:0] i_pc_second,
  input  logic [PC_WIDTH-1:0] i_target_second,
  input  logic                i_is_jump_second,
  output logic                o_hit,
  output logic [PC_WIDTH-1:0] o_target,
  output logic                o_is_jump
);
  logic [BTB_LEN-1:0] r_valid;
  btb_entry_t r_entry [BTB_LEN];
  logic w_we_f, w_we_s, w_byp_f, w_byp_s, w_arr_hit;
  logic [BTB_IDX_WIDTH-1:0] w_idx, w_idx_f, w_idx_s;
  btb_entry_t w_e_f, w_e_s, w_e_rd, w_sel;
  assign w_idx = pc_idx(i_pc);
  assign w_idx_f = pc_idx(i_pc_first);
  assign w_idx_s = pc_idx(i_pc_second);
  assign w_e_f = '{tag: pc_tag(i_pc_first), target: i_target_first, is_jump: i_is_jump_first};
  assign w_e_s = '{tag: pc_tag(i_pc_second), target: i_target_second, is_jump: i_is_jump_second};
  // flush discards every same-cycle write
  assign w_we_f = i_en_first && !i_flush;
  assign w_we_s = i_en_second && !i_flush;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_valid <= '0;
    else if (i_flush) r_valid <= '0;
    else begin
      if (w_we_f) r_valid[w_idx_f] <= 1'b1;
      if (w_we_s) r_valid[w_idx_s] <= 1'b1;
    end
  end
  // second write is issued last so it overrides first on an index collision
  always_ff @(posedge clk) begin
    if (w_we_f) r_entry[w_idx_f] <= w_e_f;
    if (w_we_s) r_entry[w_idx_s] <= w_e_s;
  end
  assign w_e_rd = r_entry[w_idx];
  assign w_arr_hit = r_valid[w_idx] && (w_e_rd.tag == pc_tag(i_pc));
  assign w_byp_s = w_we_s && (w_idx_s == w_idx) && (w_e_s.tag == pc_tag(i_pc));
  assign w_byp_f = w_we_f && (w_idx_f == w_idx) && (w_e_f.tag == pc_tag(i_pc)) &&
                   !(w_we_s && (w_idx_s == w_idx_f));
`ifdef BTB_BYPASS_EN
  assign o_hit = w_byp_s || w_byp_f || w_arr_hit;
  assign w_sel = w_byp_s ? w_e_s : w_byp_f ? w_e_f : w_e_rd;
`else
  logic w_unused;
  assign w_unused = w_byp_s ^ w_byp_f;
  assign o_hit = w_arr_hit;
  assign w_sel = w_e_rd;
`endif
  assign o_target = w_sel.target;
  assign o_is_jump = w_sel.is_jump;
endmodule

// File: rtl/btb_next_pc.sv
// btb_next_pc: fetch PC register and next-PC mux driven by BTB hit and gshare direction.
// Optional same-cycle BTB update forwarding: define BTB_BYPASS_EN.
module btb_next_pc
  import btb_next_pc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] pc,
  input  logic                gshare_pred,
  input  logic                fetch_stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                btb_flush,
  input  logic                upd_valid_first,
  input  logic [PC_WIDTH-1:0] upd_pc_first,
  input  logic [PC_WIDTH-1:0] upd_target_first,
  input  logic                upd_is_jump_first,
  input  logic                upd_taken_first,
  input  logic                upd_valid_second,
  input  logic [PC_WIDTH-1:0] upd_pc_second,
  input  logic [PC_WIDTH-1:0] upd_target_second,
  input  logic                upd_is_jump_second,
  input  logic                upd_taken_second,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target
);
  logic [PC_WIDTH-1:0] r_pc, w_next_pc;
  logic w_hit, w_is_jump;
  btb_array u_btb (
    .clk              (clk),
    .reset            (reset),
    .i_pc             (r_pc),
    .i_flush          (btb_flush),
    .i_en_first       (upd_valid_first && (upd_taken_first || upd_is_jump_first)),
    .i_pc_first       (upd_pc_first),
    .i_target_first   (upd_target_first),
    .i_is_jump_first  (upd_is_jump_first),
    .i_en_second      (upd_valid_second && (upd_taken_second || upd_is_jump_second)),
    .i_pc_second      (upd_pc_second),
    .i_target_second  (upd_target_second),
    .i_is_jump_second (upd_is_jump_second),
    .o_hit            (w_hit),
    .o_target         (pred_target),
    .o_is_jump        (w_is_jump)
  );
  assign pred_taken = w_hit && (w_is_jump || gshare_pred);
  always_comb w_next_pc = redirect_valid ? redirect_pc : fetch_stall ? r_pc : pred_taken ? pred_target : r_pc + PC_WIDTH'(4);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= RESET_PC;
    else r_pc <= w_next_pc;
  end
  assign pc = r_pc;
endmodule

// File: tb/tb_btb_next_pc.sv
// tb_btb_next_pc: directed and random checks of btb_next_pc against an array-based reference model.
module tb_btb_next_pc;
  logic clk, reset, gp, stall, rv, flush;
  logic uv1, uj1, uk1, uv2, uj2, uk2;
  logic [31:0] rpc, upc1, utg1, upc2, utg2;
  logic [31:0] pc, pred_target;
  logic pred_taken;
  int nchk = 0, nerr = 0;
  bit m_valid [64], n_valid [64], wr [64];
  logic [23:0] m_tag [64], n_tag [64];
  logic [31:0] m_tgt [64], n_tgt [64];
  logic m_jmp [64], n_jmp [64];
  logic [31:0] m_pc;

  btb_next_pc dut (
    .clk(clk), .reset(reset), .pc(pc), .gshare_pred(gp), .fetch_stall(stall),
    .redirect_valid(rv), .redirect_pc(rpc), .btb_flush(flush),
    .upd_valid_first(uv1), .upd_pc_first(upc1), .upd_target_first(utg1),
    .upd_is_jump_first(uj1), .upd_taken_first(uk1),
    .upd_valid_second(uv2), .upd_pc_second(upc2), .upd_target_second(utg2),
    .upd_is_jump_second(uj2), .upd_taken_second(uk2),
    .pred_taken(pred_taken), .pred_target(pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task clr();
    gp = 0; stall = 0; rv = 0; flush = 0; rpc = 0;
    uv1 = 0; uj1 = 0; uk1 = 0; upc1 = 0; utg1 = 0;
    uv2 = 0; uj2 = 0; uk2 = 0; upc2 = 0; utg2 = 0;
  endtask

  task model_reset();
    m_pc = 32'h8000_0000;
    foreach (m_valid[k]) m_valid[k] = 0;
  endtask

  // one clock cycle: inputs already driven at posedge+1
  task cyc();
    int i;
    logic h, j, pt;
    logic [31:0] t, np;
    #3;
    n_valid = m_valid; n_tag = m_tag; n_tgt = m_tgt; n_jmp = m_jmp;
    foreach (wr[k]) wr[k] = 0;
    if (flush) foreach (n_valid[k]) n_valid[k] = 0;
    else begin
      if (uv1 && (uk1 || uj1)) begin
        i = int'(upc1[7:2]); n_valid[i] = 1; n_tag[i] = upc1[31:8]; n_tgt[i] = utg1; n_jmp[i] = uj1; wr[i] = 1;
      end
      if (uv2 && (uk2 || uj2)) begin
        i = int'(upc2[7:2]); n_valid[i] = 1; n_tag[i] = upc2[31:8]; n_tgt[i] = utg2; n_jmp[i] = uj2; wr[i] = 1;
      end
    end
    i = int'(m_pc[7:2]);
    h = m_valid[i] && (m_tag[i] == m_pc[31:8]);
    t = m_tgt[i];
    j = m_jmp[i];
`ifdef BTB_BYPASS_EN
    if (wr[i] && n_tag[i] == m_pc[31:8]) begin
      h = 1; t = n_tgt[i]; j = n_jmp[i];
    end
`endif
    pt = h && (j || gp);
    chk("pred_taken", {31'b0, pred_taken}, {31'b0, pt});
    if (pt) chk("pred_target", pred_target, t);
    np = rv ? rpc : stall ? m_pc : pt ? t : m_pc + 32'd4;
    @(posedge clk);
    #1;
    m_valid = n_valid; m_tag = n_tag; m_tgt = n_tgt; m_jmp = n_jmp; m_pc = np;
    chk("pc", pc, m_pc);
  endtask

  task async_reset();
    #2 reset = 1;
    #1;
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_pred", {31'b0, pred_taken}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
  endtask

  task go(input logic [31:0] a);
    clr(); rv = 1; rpc = a; cyc(); clr();
  endtask

  function automatic logic [31:0] pick();
    return 32'h8000_0000 + 32'($urandom_range(0, 15) * 4) + (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
  endfunction

  initial begin
    clr();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    chk("init_pc", pc, 32'h8000_0000);
    reset = 0;
    cyc(); cyc();
    chk("step8", pc, 32'h8000_0008);
    cyc();
    async_reset();
    cyc();
    chk("post_rst", pc, 32'h8000_0004);
    // jump training
    uv1 = 1; upc1 = 32'h8000_0010; utg1 = 32'h8000_0100; uj1 = 1; uk1 = 1;
    cyc();
    go(32'h8000_0010);
    gp = 0;
    cyc();
    chk("jump_next", pc, 32'h8000_0100);
    // conditional branch
    clr(); uv1 = 1; upc1 = 32'h8000_0020; utg1 = 32'h8000_0040; uk1 = 1;
    cyc();
    go(32'h8000_0020); gp = 0; cyc();
    chk("cond_nt", pc, 32'h8000_0024);
    go(32'h8000_0020); gp = 1; cyc();
    chk("cond_t", pc, 32'h8000_0040);
    clr(); uv1 = 1; upc1 = 32'h8000_0020; utg1 = 32'h8000_0024; uk1 = 0;
    cyc();
    go(32'h8000_0020); gp = 1; cyc();
    chk("nt_keeps", pc, 32'h8000_0040);
    // tag alias misses
    go(32'h8000_0110); gp = 1; cyc();
    chk("alias_miss", pc, 32'h8000_0114);
    // same-index dual write: second wins
    clr();
    uv1 = 1; upc1 = 32'h8000_0010; utg1 = 32'h8000_00A0; uj1 = 1; uk1 = 1;
    uv2 = 1; upc2 = 32'h8000_0010; utg2 = 32'h8000_00B0; uj2 = 1; uk2 = 1;
    cyc();
    go(32'h8000_0010); cyc();
    chk("second_wins", pc, 32'h8000_00B0);
    // redirect beats stall and prediction
    go(32'h8000_0010); rv = 1; rpc = 32'h8000_0200; stall = 1; gp = 1; cyc();
    chk("redir_prio", pc, 32'h8000_0200);
    // stall holds
    clr(); stall = 1; cyc();
    chk("stall", pc, 32'h8000_0200);
    // flush with same-cycle update
    clr(); flush = 1; uv1 = 1; upc1 = 32'h8000_0204; utg1 = 32'h8000_0300; uj1 = 1; uk1 = 1;
    cyc();
    go(32'h8000_0010); cyc();
    chk("flush_miss", pc, 32'h8000_0014);
    go(32'h8000_0204); cyc();
    chk("flush_upd", pc, 32'h8000_0208);
    // update matching current pc: same-cycle hit only with bypass
    go(32'h8000_0030);
    uv2 = 1; upc2 = 32'h8000_0030; utg2 = 32'h8000_0080; uj2 = 1; uk2 = 1;
    cyc();
`ifdef BTB_BYPASS_EN
    chk("byp_same", pc, 32'h8000_0080);
`else
    chk("byp_same", pc, 32'h8000_0034);
`endif
    go(32'h8000_0030); cyc();
    chk("byp_later", pc, 32'h8000_0080);
    // random traffic around a small pc pool
    for (int n = 0; n < 500; n++) begin
      clr();
      gp = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 4) == 0);
      rpc = pick();
      flush = ($urandom_range(0, 29) == 0);
      uv1 = ($urandom_range(0, 1) == 1); upc1 = ($urandom_range(0, 2) == 0) ? m_pc : pick(); utg1 = pick();
      uj1 = 1'($urandom_range(0, 1)); uk1 = 1'($urandom_range(0, 1));
      uv2 = ($urandom_range(0, 1) == 1); upc2 = ($urandom_range(0, 2) == 0) ? upc1 : pick(); utg2 = pick();
      uj2 = 1'($urandom_range(0, 1)); uk2 = 1'($urandom_range(0, 1));
      if (m_pc > 32'h8000_0400) begin rv = 1; rpc = pick(); end
      cyc();
      if (n == 250) async_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/btb_next_pc.md
Name: btb_next_pc

Overview:
- Fetch-side next-PC stage, directly downstream of the gshare direction predictor.
- Holds the architectural fetch PC register and drives it to gshare and the I-cache.
- Looks the PC up in a direct-mapped branch target buffer (BTB) and combines the hit with gshare's taken bit to choose the next PC.
- Trained by up to two resolved control-flow instructions per cycle from execute, using the same first/second ordering as the gshare update ports.

Parameters:
- PC_WIDTH, 32, fetch PC width.
- BTB_IDX_WIDTH, 6, log2 of BTB entries (64 entries).
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- pc  output  PC_WIDTH  current fetch PC, to gshare and I-cache.
- gshare_pred  input  1  gshare taken prediction for the current pc.
- fetch_stall  input  1  hold pc this cycle.
- redirect_valid  input  1  execute mispredict or exception redirect.
- redirect_pc  input  PC_WIDTH  redirect target.
- btb_flush  input  1  invalidate all BTB entries (fence.i).
- upd_valid_first  input  1  first resolved control-flow instr valid.
- upd_pc_first  input  PC_WIDTH  its pc.
- upd_target_first  input  PC_WIDTH  its resolved target.
- upd_is_jump_first  input  1  unconditional jump (jal/jalr).
- upd_taken_first  input  1  resolved taken.
- upd_valid_second, upd_pc_second, upd_target_second, upd_is_jump_second, upd_taken_second  input  1/PC_WIDTH/PC_WIDTH/1/1  same fields for the second, younger instruction.
- pred_taken  output  1  current pc predicted taken.
- pred_target  output  PC_WIDTH  predicted target; valid when pred_taken=1.

Behaviour:
- Address split:
  - idx = pc[BTB_IDX_WIDTH+1:2].
  - tag = pc[PC_WIDTH-1:BTB_IDX_WIDTH+2].
  - pc[1:0] is ignored.
- Each entry holds valid, tag, target and is_jump.
  - The valid vector is asynchronously cleared by reset.
  - Tag, target and is_jump have no reset.
- Lookup is combinational from the pc register:
  - hit = valid[idx] && tag match.
  - pred_taken = hit && (is_jump || gshare_pred).
  - pred_target = entry target.
- Next pc priority:
  1. redirect_valid → redirect_pc.
  2. else fetch_stall → hold.
  3. else pred_taken → pred_target.
  4. else pc+4, wrapping modulo 2^PC_WIDTH.
- The pc register updates every cycle; its effect is visible at the next edge.
- Reset: pc=RESET_PC, all valid=0, so pred_taken=0 and pred_target is don't-care.
- Update rules, applied at the clock edge and visible to lookup on the following cycle:
  - Valid && (taken || is_jump): write valid=1, tag, target and is_jump at the update's idx (allocate or overwrite).
  - Valid && not taken && !is_jump: no write; the entry is kept and direction is left to gshare.
  - First and second write the same idx: the second (younger) write wins completely.
  - Different indices: both writes occur in the same cycle.
- btb_flush clears all valid bits at the edge. Any updates in the same cycle are discarded (flush wins).
- redirect, stall and update are independent: a redirect in the same cycle as an update still performs the update.
- Reset asserted mid-operation immediately forces pc=RESET_PC and clears valids; the first post-reset lookup misses.
- No combinational path from gshare_pred to pc register feedback other than through the next-pc mux. gshare's cur_pred depends only on pc and its own state, so there is no loop.

Optional Feature:
- Macro BTB_BYPASS_EN.
- Defined: same-cycle forwarding. If an update writing an entry (after second-over-first priority) has the same idx and tag as the current pc, lookup uses the update's target and is_jump and treats the entry as hit.
  - A same-cycle btb_flush suppresses the forwarding.
- Undefined: lookup sees array contents only, giving a one-cycle write-to-read latency.

Decomposition:
- Shared params header/package:
  - PC_WIDTH, BTB_IDX_WIDTH and RESET_PC.
  - Derived BTB_TAG_WIDTH = PC_WIDTH-BTB_IDX_WIDTH-2.
  - BTB_LEN = 1<<BTB_IDX_WIDTH.
  - Entry typedef {tag, target, is_jump}.
- One sub-module, btb_array: valid vector, entry storage, dual update with priority, flush, lookup and the optional bypass.
- The top level holds the pc register and next-pc mux.

Test Plan:
- Reset check: assert reset async mid-cycle → pc=0x8000_0000 immediately, pred_taken=0; after release, with no stall, pc steps 0x8000_0004 and then 0x8000_0008.
- Jump training: update first {pc=0x8000_0010, target=0x8000_0100, is_jump=1, taken=1}. On a later visit to pc 0x8000_0010, pred_taken=1 regardless of gshare_pred, and the next pc is 0x8000_0100.
- Conditional branch entry {pc=0x8000_0020, target=0x8000_0040}: gshare_pred=0 → next pc 0x8000_0024; gshare_pred=1 → next pc 0x8000_0040. An update with not-taken leaves the entry valid.
- Tag alias and same-index conflict:
  - pc 0x8000_0010 and 0x8000_0110 share idx 4; lookup of the non-resident one misses.
  - Same-cycle first/second writes to idx 4 with targets 0xA0/0xB0 → the entry holds 0xB0.
- Redirect priority: redirect_valid=1 with redirect_pc=0x8000_0200 while fetch_stall=1 and pred_taken=1 → next pc 0x8000_0200.
- Flush: btb_flush plus a same-cycle taken update → every lookup misses afterwards. With BTB_BYPASS_EN, an update matching the current pc gives a same-cycle hit; without it, the hit appears one cycle later.
